// File: rtl/counter_updown_mod_if.sv
// Control and status bundle for the up/down modulo counter.
//   en, up, load, load_value : controls driven by the master
//   out, tc, load_err        : registered status returned by the counter
//   at_max, at_min           : combinational range flags derived from out
interface counter_updown_mod_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             load_err;
    logic             at_max;
    logic             at_min;

    modport master (
        output en, up, load, load_value,
        input  out, tc, load_err, at_max, at_min
    );

    modport slave (
        input  en, up, load, load_value,
        output out, tc, load_err, at_max, at_min
    );
endinterface

// File: rtl/counter_updown_mod.sv
// Parametrised up/down modulo counter with parallel load, wrap or saturate
// behaviour at the range ends, and terminal-count / load-error pulses.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset
//   bus    : counter_updown_mod_if.slave (controls in, count and status out)
module counter_updown_mod #(
    parameter int unsigned      WIDTH       = 8,
    parameter longint unsigned  MODULUS     = 256,
    parameter bit               SATURATE    = 1'b0,
    parameter longint unsigned  RESET_VALUE = 0
) (
    input  logic               clk,
    input  logic               reset,
    counter_updown_mod_if.slave bus
);
    // One extra bit so MODULUS == 2**WIDTH compares without truncation.
    localparam int unsigned CW = WIDTH + 1;
    localparam logic [CW-1:0]    MOD_X = CW'(MODULUS);
    localparam logic [CW-1:0]    MAX_X = CW'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VALUE);

    // Elaboration-time parameter legality checks.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "counter_updown_mod: WIDTH must be 1..32");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $fatal(1, "counter_updown_mod: MODULUS must be 2..2**WIDTH");
    end
    if (RESET_VALUE >= MODULUS) begin : g_bad_reset_value
        $fatal(1, "counter_updown_mod: RESET_VALUE must be < MODULUS");
    end

    logic [CW-1:0]    cnt_x;
    logic [CW-1:0]    load_x;
    logic [WIDTH-1:0] next_out;
    logic             next_tc;
    logic             next_err;

    assign cnt_x  = {1'b0, bus.out};
    assign load_x = {1'b0, bus.load_value};

    // Next-state selection: load beats count beats hold.
    always_comb begin
        next_out = bus.out;
        next_tc  = 1'b0;
        next_err = 1'b0;
        if (bus.load) begin
            if (load_x < MOD_X) begin
                next_out = bus.load_value;
            end else begin
                next_out = MAX_W;
                next_err = 1'b1;
            end
        end else if (bus.en) begin
            if (bus.up) begin
                if (cnt_x == MAX_X) begin
                    next_tc  = 1'b1;
                    next_out = SATURATE ? bus.out : '0;
                end else begin
                    next_out = WIDTH'(cnt_x + CW'(1));
                end
            end else begin
                if (cnt_x == '0) begin
                    next_tc  = 1'b1;
                    next_out = SATURATE ? bus.out : MAX_W;
                end else begin
                    next_out = WIDTH'(cnt_x - CW'(1));
                end
            end
        end
    end

    // Count and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out      <= RST_W;
            bus.tc       <= 1'b0;
            bus.load_err <= 1'b0;
        end else begin
            bus.out      <= next_out;
            bus.tc       <= next_tc;
            bus.load_err <= next_err;
        end
    end

    // Range flags follow out with no added latency.
    assign bus.at_max = (cnt_x == MAX_X);
    assign bus.at_min = (bus.out == '0);
endmodule

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
Parametrised up/down modulo counter. It is the next generation of the fixed 8-bit free-running counter.
- Adds: configurable width and modulus, count direction, enable, parallel load, wrap or saturate mode, and terminal-count / load-error status.
- Intended as a reusable sequential leaf for the architecture test designs. It is checked cycle-by-cycle against a behavioural model in a testbench.

Parameters:
WIDTH, 8, counter and load width in bits (1..32).
MODULUS, 256, count range is 0..MODULUS-1; legal range is 2 <= MODULUS <= 2**WIDTH.
SATURATE, 0, 0 = wrap at range ends, 1 = hold at range ends.
RESET_VALUE, 0, value of out after reset; must be < MODULUS.

Ports:
clk  input  1  rising-edge clock; the only clock.
reset  input  1  synchronous, active-high reset.
en  input  1  count enable.
up  input  1  direction: 1 = increment, 0 = decrement; sampled only when counting.
load  input  1  parallel load strobe.
load_value  input  WIDTH  value to load.
out  output  WIDTH  registered count.
tc  output  1  registered one-cycle terminal-count pulse.
load_err  output  1  registered one-cycle out-of-range-load pulse.
at_max  output  1  combinational, (out == MODULUS-1).
at_min  output  1  combinational, (out == 0).

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset), sampled on rising clk only. There is no asynchronous path.
- Priority at each rising edge: reset > load > en > hold.
- Reset: out <= RESET_VALUE, tc <= 0, load_err <= 0. This applies mid-count and when load or en are also asserted.
- Load (load=1, reset=0):
  - If load_value < MODULUS: out <= load_value.
  - Otherwise: out <= MODULUS-1 and load_err <= 1 for one cycle.
  - en and up are ignored in a load cycle; tc <= 0.
- Count up (en=1, up=1, no load):
  - If out < MODULUS-1: out <= out+1.
  - If out == MODULUS-1: out <= 0 when SATURATE=0, or out holds when SATURATE=1; in both cases tc <= 1.
- Count down (en=1, up=0, no load):
  - If out > 0: out <= out-1.
  - If out == 0: out <= MODULUS-1 when SATURATE=0, or out holds when SATURATE=1; in both cases tc <= 1.
- Hold (en=0, no load): out unchanged; tc <= 0, load_err <= 0.
- tc and load_err are 1 for exactly the cycle after the triggering edge, then return to 0.
  - With SATURATE=1 and en held at the limit, tc re-asserts every cycle.
- Latency: out reflects the action one clock after the sampling edge. at_max and at_min track out with zero latency.
- Arithmetic: comparisons and next-state computation use WIDTH+1 bits internally, so MODULUS == 2**WIDTH wraps correctly with no truncation error.
- Direction change mid-count takes effect on the next enabled edge with no bubble.
- Illegal parameter combinations (MODULUS out of range, RESET_VALUE >= MODULUS) are caught by an elaboration-time check that stops simulation.
- Default parameters reproduce an 8-bit free-running up counter.
  - Reset, then en=1, up=1 gives out = cycles since reset, mod 256.

Test Plan:
1. Defaults, reset 1 cycle, then en=1, up=1 for 600 cycles -> out equals model counter every edge; out wraps 255->0 twice; tc high exactly on the two cycles after out==255 was sampled.
2. MODULUS=10, SATURATE=0, up count 25 cycles from reset -> sequence 0..9,0..9,0..4; tc pulses after each 9->0 edge; at_max high whenever out==9.
3. MODULUS=10, SATURATE=1, load 2, down for 5 cycles -> out 2,1,0,0,0,0; tc high on the 3 cycles following edges sampled at out==0; then up for 12 cycles -> out climbs to 9 and holds; tc repeats while held.
4. MODULUS=10, count to 6, assert load with load_value=3 and en=1 -> out=3 next cycle, no tc. Then load_value=12 -> out=9, load_err pulses exactly 1 cycle.
5. RESET_VALUE=5, count to 8, assert reset together with load=1, load_value=1 -> out=5, tc=0, load_err=0 on the next cycle; counting resumes from 5 after reset drops.
6. Defaults, en toggled randomly with up flipping every 7 cycles for 2000 cycles -> out matches model each edge; en=0 cycles hold out unchanged with tc=0.
